// File: rtl/booth_pkg.sv
// Shared definitions for the radix-4 Booth partial-product stream:
// digit encoding, FSM states and size helpers.
package booth_pkg;

  typedef enum logic [2:0] {B_ZERO, B_P1, B_P2, B_M1, B_M2} booth_digit_e;

  typedef enum logic {IDLE, RUN} booth_state_e;

  function automatic int unsigned ndig(input int unsigned width);
    return width / 2 + 1;
  endfunction

  function automatic int unsigned beats(input int unsigned width, input int unsigned lanes);
    return (ndig(width) + lanes - 1) / lanes;
  endfunction

  function automatic int unsigned ppw(input int unsigned width);
    return width + 2;
  endfunction

  function automatic int unsigned idxw(input int unsigned width, input int unsigned lanes);
    int unsigned b;
    b = beats(width, lanes);
    return (b <= 2) ? 1 : $clog2(b);
  endfunction

  function automatic booth_digit_e decode(input logic [2:0] trip);
    case (trip)
      3'b001, 3'b010: return B_P1;
      3'b011:         return B_P2;
      3'b100:         return B_M2;
      3'b101, 3'b110: return B_M1;
      default:        return B_ZERO;
    endcase
  endfunction

endpackage

// File: rtl/booth2_row.sv
// One Booth-2 partial-product row: one's-complement row, +1 correction
// and sign-extension-prevention bit for a single multiplier triplet.
module booth2_row
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0]   xe,
  input  logic [2:0]       trip,
  output logic [WIDTH+1:0] row,
  output logic             neg,
  output logic             e
);

  booth_digit_e     dig;
  logic [WIDTH+1:0] mag;

  always_comb begin
    dig = decode(trip);
    mag = '0;
    row = '0;
    neg = 1'b0;
    e   = 1'b1;
    case (dig)
      B_P1, B_M1: mag = {xe[WIDTH], xe};
      B_P2, B_M2: mag = {xe, 1'b0};
      default:    mag = '0;
    endcase
    if (dig == B_M1 || dig == B_M2) begin
      row = ~mag;
      neg = 1'b1;
    end else begin
      row = mag;
    end
    if (dig != B_ZERO) e = ~row[WIDTH+1];
  end

endmodule

// File: rtl/booth2_pp_stream.sv
// Streaming radix-4 Booth partial-product generator: accepts an operand
// pair, then emits all digit rows LANES at a time with backpressure.
module booth2_pp_stream
  import booth_pkg::*;
#(
  parameter  int unsigned WIDTH = 32,
  parameter  int unsigned LANES = 4,
  localparam int unsigned NDIG  = ndig(WIDTH),
  localparam int unsigned BEATS = beats(WIDTH, LANES),
  localparam int unsigned PPW   = ppw(WIDTH),
  localparam int unsigned IDXW  = idxw(WIDTH, LANES),
  localparam int unsigned YEW   = 2 * NDIG + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_x,
  input  logic [WIDTH-1:0]       in_y,
  input  logic                   in_signed,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*PPW-1:0]   out_pp,
  output logic [LANES-1:0]       out_neg,
  output logic [LANES-1:0]       out_e,
  output logic [LANES-1:0]       out_mask,
  output logic [IDXW-1:0]        out_idx,
  output logic                   out_last
);

  booth_state_e state_q, state_d;
  logic [WIDTH:0]         xe_q, xe_d, xe_in, src_x;
  logic [YEW-1:0]         ye_q, ye_d, ye_in, src_y;
  logic [LANES*PPW-1:0]   out_pp_q, out_pp_d;
  logic [LANES-1:0]       out_neg_q, out_neg_d;
  logic [LANES-1:0]       out_e_q, out_e_d;
  logic [LANES-1:0]       out_mask_q, out_mask_d;
  logic [IDXW-1:0]        out_idx_q, out_idx_d;
  logic                   out_last_q, out_last_d;

  logic                   accept, hs;
  int unsigned            src_beat;
  logic [LANES-1:0][2:0]     lane_trip;
  logic [LANES-1:0]          lane_real;
  logic [LANES-1:0][PPW-1:0] lane_row;
  logic [LANES-1:0]          lane_neg, lane_e;

  // The row generators see the incoming operands directly on accept so that
  // beat 0 is registered in the same cycle, giving back-to-back operation.
  always_comb begin : src_sel
    xe_in    = {in_signed & in_x[WIDTH-1], in_x};
    ye_in    = {{2{in_signed & in_y[WIDTH-1]}}, in_y, 1'b0};
    in_ready = !rst && ((state_q == IDLE) ||
                        ((state_q == RUN) && out_ready && out_last_q));
    accept   = in_valid && in_ready;
    hs       = (state_q == RUN) && out_ready;
    src_x    = accept ? xe_in : xe_q;
    src_y    = accept ? ye_in : ye_q;
    src_beat = accept ? 0 : 32'(out_idx_q) + 32'd1;
  end

  always_comb begin : lane_sel
    int unsigned    dig;
    logic [YEW-1:0] sh;
    dig       = 0;
    sh        = '0;
    lane_trip = '0;
    lane_real = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      dig          = src_beat * LANES + k;
      lane_real[k] = (dig < NDIG);
      sh           = src_y >> (2 * dig);
      lane_trip[k] = sh[2:0];
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    booth2_row #(.WIDTH(WIDTH)) u_row (
      .xe   (src_x),
      .trip (lane_trip[k]),
      .row  (lane_row[k]),
      .neg  (lane_neg[k]),
      .e    (lane_e[k])
    );
  end

  always_comb begin : next_state
    state_d    = state_q;
    xe_d       = xe_q;
    ye_d       = ye_q;
    out_pp_d   = out_pp_q;
    out_neg_d  = out_neg_q;
    out_e_d    = out_e_q;
    out_mask_d = out_mask_q;
    out_idx_d  = out_idx_q;
    out_last_d = out_last_q;
    if (accept) begin
      xe_d    = xe_in;
      ye_d    = ye_in;
      state_d = RUN;
    end else if (hs && out_last_q) begin
      state_d    = IDLE;
      out_pp_d   = '0;
      out_neg_d  = '0;
      out_e_d    = '0;
      out_mask_d = '0;
      out_idx_d  = '0;
      out_last_d = 1'b0;
    end
    if (accept || (hs && !out_last_q)) begin
      for (int unsigned k = 0; k < LANES; k++) begin
        out_pp_d[k*PPW +: PPW] = lane_real[k] ? lane_row[k] : '0;
        out_neg_d[k]           = lane_real[k] & lane_neg[k];
        out_e_d[k]             = lane_real[k] & lane_e[k];
      end
      out_mask_d = lane_real;
      out_idx_d  = IDXW'(src_beat);
      out_last_d = (src_beat == BEATS - 1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      xe_q       <= '0;
      ye_q       <= '0;
      out_pp_q   <= '0;
      out_neg_q  <= '0;
      out_e_q    <= '0;
      out_mask_q <= '0;
      out_idx_q  <= '0;
      out_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      xe_q       <= xe_d;
      ye_q       <= ye_d;
      out_pp_q   <= out_pp_d;
      out_neg_q  <= out_neg_d;
      out_e_q    <= out_e_d;
      out_mask_q <= out_mask_d;
      out_idx_q  <= out_idx_d;
      out_last_q <= out_last_d;
    end
  end

  assign out_valid = (state_q == RUN);
  assign out_pp    = out_pp_q;
  assign out_neg   = out_neg_q;
  assign out_e     = out_e_q;
  assign out_mask  = out_mask_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_booth2_pp_stream.sv
// Directed bench for booth2_pp_stream: WIDTH=32/LANES=4 plus WIDTH=8/LANES=3,
// checking rows, handshake, backpressure, reset and reconstructed products.
module tb_booth2_pp_stream;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Main instance: WIDTH=32, LANES=4 -> NDIG=17, BEATS=5, PPW=34, idx 3 bits
  logic         in_valid, in_ready, in_signed, out_valid, out_ready, out_last;
  logic [31:0]  in_x, in_y;
  logic [135:0] out_pp;
  logic [3:0]   out_neg, out_e, out_mask;
  logic [2:0]   out_idx;

  booth2_pp_stream #(.WIDTH(32), .LANES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_signed(in_signed), .out_valid(out_valid),
    .out_ready(out_ready), .out_pp(out_pp), .out_neg(out_neg), .out_e(out_e),
    .out_mask(out_mask), .out_idx(out_idx), .out_last(out_last)
  );

  // Small instance: WIDTH=8, LANES=3 -> NDIG=5, BEATS=2, PPW=10, idx 1 bit
  logic        b_in_valid, b_in_ready, b_in_signed, b_out_valid, b_out_ready, b_out_last;
  logic [7:0]  b_in_x, b_in_y;
  logic [29:0] b_out_pp;
  logic [2:0]  b_out_neg, b_out_e, b_out_mask;
  logic [0:0]  b_out_idx;

  booth2_pp_stream #(.WIDTH(8), .LANES(3)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_x(b_in_x), .in_y(b_in_y), .in_signed(b_in_signed), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_pp(b_out_pp), .out_neg(b_out_neg), .out_e(b_out_e),
    .out_mask(b_out_mask), .out_idx(b_out_idx), .out_last(b_out_last)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [33:0] rows [17];
  logic        negs [17];
  logic        es   [17];

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic start(input logic [31:0] x, input logic [31:0] y, input logic s);
    in_valid  = 1'b1;
    in_x      = x;
    in_y      = y;
    in_signed = s;
    #1;
    check("start in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
  endtask

  // Drain one transaction from the main instance, checking beat framing,
  // optionally stalling at one beat and/or launching the next pair on the last beat.
  task automatic collect(input string t, input logic [63:0] exp_prod, input int stall_beat,
                         input bit b2b, input logic [31:0] nx, input logic [31:0] ny,
                         input logic ns);
    logic [63:0]  sum, r;
    logic [135:0] snap_pp;
    logic [16:0]  snap_ctl;
    int           d;
    sum       = '0;
    out_ready = 1'b1;
    for (int b = 0; b < 5; b++) begin
      check($sformatf("%s valid b%0d", t, b), out_valid, 1);
      check($sformatf("%s idx b%0d", t, b), out_idx, b);
      check($sformatf("%s last b%0d", t, b), out_last, (b == 4));
      check($sformatf("%s mask b%0d", t, b), out_mask, (b < 4) ? 4'hF : 4'h1);
      if (b < 4) begin
        in_x      = ~in_x;
        in_y      = in_y ^ 32'h5A5A_A5A5;
        in_signed = ~in_signed;
        #1;
        check($sformatf("%s in_ready b%0d", t, b), in_ready, 0);
      end
      if (b == stall_beat) begin
        out_ready = 1'b0;
        snap_pp   = out_pp;
        snap_ctl  = {out_valid, out_neg, out_e, out_mask, out_idx, out_last};
        for (int s = 0; s < 3; s++) begin
          tick();
          check($sformatf("%s stall pp c%0d", t, s), out_pp, snap_pp);
          check($sformatf("%s stall ctl c%0d", t, s),
                {out_valid, out_neg, out_e, out_mask, out_idx, out_last}, snap_ctl);
        end
        out_ready = 1'b1;
      end
      for (int k = 0; k < 4; k++) begin
        d = b * 4 + k;
        if (d < 17) begin
          rows[d] = out_pp[k*34 +: 34];
          negs[d] = out_neg[k];
          es[d]   = out_e[k];
          r       = {{30{rows[d][33]}}, rows[d]};
          sum     = sum + ((r + 64'(negs[d])) << (2 * d));
        end
      end
      if (b == 4) begin
        check($sformatf("%s pad lanes", t), {out_pp[135:34], out_neg[3:1], out_e[3:1]}, 0);
        if (b2b) begin
          in_valid  = 1'b1;
          in_x      = nx;
          in_y      = ny;
          in_signed = ns;
        end
        #1;
        check($sformatf("%s last in_ready", t), in_ready, 1);
      end
      tick();
      in_valid = 1'b0;
    end
    if (!b2b) check($sformatf("%s idle valid", t), out_valid, 0);
    check($sformatf("%s product", t), sum, exp_prod);
  endtask

  logic [7:0]  vx [5] = '{8'h80, 8'hFF, 8'h80, 8'hA5, 8'hA5};
  logic [7:0]  vy [5] = '{8'h80, 8'hFF, 8'h7F, 8'h3C, 8'h3C};
  logic        vs [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [63:0] vp [5] = '{64'h4000, 64'hFE01, 64'hFFFF_FFFF_FFFF_C080,
                          64'h26AC, 64'hFFFF_FFFF_FFFF_EAAC};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] sum8, r8;
    logic [9:0]  row8;
    int          d8;

    rst = 1'b1;
    in_valid = 1'b0; in_x = '0; in_y = '0; in_signed = 1'b0; out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_x = '0; b_in_y = '0; b_in_signed = 1'b0; b_out_ready = 1'b0;
    tick();
    tick();
    check("rst outputs", {out_valid, out_pp, out_neg, out_e, out_mask, out_idx, out_last}, 0);
    check("rst in_ready", in_ready, 0);
    rst = 1'b0;
    #1;
    check("post-rst in_ready", in_ready, 1);

    // 1: signed 3 * -1
    start(32'd3, 32'hFFFF_FFFF, 1'b1);
    collect("t1", 64'hFFFF_FFFF_FFFF_FFFD, -1, 0, '0, '0, 1'b0);
    check("t1 d0", {rows[0], negs[0], es[0]}, {34'h3_FFFF_FFFC, 1'b1, 1'b0});
    for (int d = 1; d < 17; d++)
      check($sformatf("t1 d%0d", d), {rows[d], negs[d], es[d]}, {34'h0, 1'b0, 1'b1});

    // 2: unsigned max * max; digit 16 carries the top multiplier bit
    start(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    collect("t2", 64'hFFFF_FFFE_0000_0001, -1, 0, '0, '0, 1'b0);
    check("t2 d0", {rows[0], negs[0], es[0]}, {34'h3_0000_0000, 1'b1, 1'b0});
    for (int d = 1; d < 16; d++)
      check($sformatf("t2 d%0d", d), {rows[d], negs[d], es[d]}, {34'h0, 1'b0, 1'b1});
    check("t2 d16", {rows[16], negs[16], es[16]}, {34'h0_FFFF_FFFF, 1'b0, 1'b1});

    // 3: signed -5 * 2
    start(32'hFFFF_FFFB, 32'd2, 1'b1);
    collect("t3", 64'hFFFF_FFFF_FFFF_FFF6, -1, 0, '0, '0, 1'b0);
    check("t3 d0", {rows[0], negs[0], es[0]}, {34'h0_0000_0009, 1'b1, 1'b1});
    check("t3 d1", {rows[1], negs[1], es[1]}, {34'h3_FFFF_FFFB, 1'b0, 1'b0});
    for (int d = 2; d < 17; d++)
      check($sformatf("t3 d%0d", d), {rows[d], negs[d], es[d]}, {34'h0, 1'b0, 1'b1});

    // 4: backpressure at beat 2
    start(32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    collect("t4", 64'h1234_5678 * 64'h9ABC_DEF0, 2, 0, '0, '0, 1'b0);

    // 5: back-to-back transactions
    start(32'h8000_0000, 32'h8000_0000, 1'b1);
    collect("t5a", 64'h4000_0000_0000_0000, -1, 1, 32'h7FFF_FFFF, 32'h8000_0001, 1'b1);
    collect("t5b", 64'hC000_0000_FFFF_FFFF, -1, 0, '0, '0, 1'b0);

    // 6: reset mid-transaction
    start(32'h0000_1234, 32'h0000_5678, 1'b0);
    out_ready = 1'b1;
    tick();
    tick();
    check("t6 idx before rst", out_idx, 2);
    rst = 1'b1;
    tick();
    check("t6 rst outputs", {out_valid, out_pp, out_neg, out_e, out_mask, out_idx, out_last}, 0);
    check("t6 rst in_ready", in_ready, 0);
    rst = 1'b0;
    #1;
    check("t6 in_ready after rst", in_ready, 1);
    start(32'hFFFF_FF00, 32'h0000_0100, 1'b1);
    collect("t6b", 64'hFFFF_FFFF_FFFF_0000, -1, 0, '0, '0, 1'b0);

    // 7: WIDTH=8, LANES=3 instance, both modes
    b_out_ready = 1'b1;
    for (int v = 0; v < 5; v++) begin
      b_in_valid  = 1'b1;
      b_in_x      = vx[v];
      b_in_y      = vy[v];
      b_in_signed = vs[v];
      #1;
      check($sformatf("t7.%0d in_ready", v), b_in_ready, 1);
      tick();
      b_in_valid = 1'b0;
      sum8 = '0;
      for (int b = 0; b < 2; b++) begin
        check($sformatf("t7.%0d valid b%0d", v, b), b_out_valid, 1);
        check($sformatf("t7.%0d idx/last/mask b%0d", v, b),
              {b_out_idx, b_out_last, b_out_mask}, (b == 0) ? 5'b0_0_111 : 5'b1_1_011);
        for (int k = 0; k < 3; k++) begin
          d8 = b * 3 + k;
          if (d8 < 5) begin
            row8 = b_out_pp[k*10 +: 10];
            r8   = {{54{row8[9]}}, row8};
            sum8 = sum8 + ((r8 + 64'(b_out_neg[k])) << (2 * d8));
          end
        end
        if (b == 1)
          check($sformatf("t7.%0d pad lane", v), {b_out_pp[29:20], b_out_neg[2], b_out_e[2]}, 0);
        tick();
      end
      check($sformatf("t7.%0d idle", v), b_out_valid, 0);
      check($sformatf("t7.%0d product", v), sum8, vp[v]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
